// File: rtl/tb_dual_port_mem_if.sv
// tb_dual_port_mem_if
// Purpose: one req/gnt/rvalid memory port (request side plus response side).
// Signals:
//   req, addr, we, be, wdata   request from the requester (core or harness)
//   gnt                        grant from the memory, combinational from req
//   rvalid, rdata, err         registered response from the memory
// Modports: master = requester side, slave = memory side.
interface tb_dual_port_mem_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    req;
  logic                    gnt;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] be;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    rvalid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    err;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/tb_dual_port_mem.sv
// tb_dual_port_mem
// Purpose: simulation memory model with an instruction fetch port and a data
// load/store port. Preloaded from a flat byte vector, fixed response latency,
// periodic grant back-pressure, byte-enable writes and error responses.
// Ports:
//   clk_i     clock, rising edge
//   rst_i     asynchronous active-high reset (reloads the array)
//   instr_if  fetch port (slave side); we/be/wdata are ignored
//   data_if   load/store port (slave side)
module tb_dual_port_mem #(
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter int unsigned           DEPTH_WORDS  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter int unsigned           INIT_BYTES   = 48,
  parameter logic [INIT_BYTES*8-1:0] INIT_CONTENT = '0,
  parameter int unsigned           LATENCY      = 1,
  parameter int unsigned           STALL_PERIOD = 0
) (
  input logic               clk_i,
  input logic               rst_i,
  tb_dual_port_mem_if.slave instr_if,
  tb_dual_port_mem_if.slave data_if
);

  localparam int unsigned BPW   = DATA_WIDTH / 8;
  localparam int unsigned OFF_W = $clog2(BPW);
  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W = (STALL_PERIOD > 2) ? $clog2(STALL_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'((STALL_PERIOD >= 2) ? STALL_PERIOD - 1 : 0);
  localparam logic [ADDR_WIDTH:0] SIZE_BYTES = (ADDR_WIDTH+1)'(DEPTH_WORDS * BPW);

  if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
    $fatal(1, "tb_dual_port_mem: LATENCY must be within 1..8");
  end
  if (STALL_PERIOD == 1) begin : g_bad_stall
    $fatal(1, "tb_dual_port_mem: STALL_PERIOD of 1 would never grant");
  end
  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
    $fatal(1, "tb_dual_port_mem: DATA_WIDTH must be 32 or 64");
  end
  if (INIT_BYTES > DEPTH_WORDS * BPW) begin : g_bad_init
    $fatal(1, "tb_dual_port_mem: INIT_CONTENT larger than the array");
  end

  // Byte i of the init vector sits at the most-significant end first.
  function automatic logic [7:0] init_byte(input int unsigned i);
    if (i < INIT_BYTES) return INIT_CONTENT[(INIT_BYTES-1-i)*8 +: 8];
    return 8'h00;
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

  logic [CNT_W-1:0]      i_cnt_q, i_cnt_d, d_cnt_q, d_cnt_d;
  logic                  i_stall, d_stall, i_acc, d_acc, i_ok, d_ok;
  logic [ADDR_WIDTH:0]   i_off, d_off;
  logic [IDX_W-1:0]      i_idx, d_idx;
  logic [DATA_WIDTH-1:0] i_rdata_d, d_rdata_d;

  logic [LATENCY-1:0]    i_vld_q, i_err_q, d_vld_q, d_err_q;
  logic [DATA_WIDTH-1:0] i_data_q [LATENCY];
  logic [DATA_WIDTH-1:0] d_data_q [LATENCY];

  assign i_stall = (STALL_PERIOD >= 2) && (i_cnt_q == CNT_MAX);
  assign d_stall = (STALL_PERIOD >= 2) && (d_cnt_q == CNT_MAX);
  assign instr_if.gnt = instr_if.req && !i_stall;
  assign data_if.gnt  = data_if.req && !d_stall;
  assign i_acc = instr_if.req && instr_if.gnt;
  assign d_acc = data_if.req && data_if.gnt;

  // One extra bit so a borrow flags addresses below BASE_ADDR.
  assign i_off = {1'b0, instr_if.addr} - {1'b0, BASE_ADDR};
  assign d_off = {1'b0, data_if.addr} - {1'b0, BASE_ADDR};
  assign i_ok  = !i_off[ADDR_WIDTH] && (i_off < SIZE_BYTES) &&
                 (instr_if.addr[OFF_W-1:0] == '0);
  assign d_ok  = !d_off[ADDR_WIDTH] && (d_off < SIZE_BYTES) &&
                 (data_if.addr[OFF_W-1:0] == '0);
  assign i_idx = i_off[OFF_W +: IDX_W];
  assign d_idx = d_off[OFF_W +: IDX_W];

  // Reads take the array contents before this edge's write lands.
  assign i_rdata_d = (i_acc && i_ok) ? mem_q[i_idx] : '0;
  assign d_rdata_d = (d_acc && d_ok && !data_if.we) ? mem_q[d_idx] : '0;

  always_comb begin
    i_cnt_d = i_cnt_q;
    d_cnt_d = d_cnt_q;
    if (STALL_PERIOD >= 2) begin
      i_cnt_d = (i_cnt_q == CNT_MAX) ? '0 : i_cnt_q + 1'b1;
      d_cnt_d = (d_cnt_q == CNT_MAX) ? '0 : d_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned w = 0; w < DEPTH_WORDS; w++) begin
        for (int unsigned b = 0; b < BPW; b++) begin
          mem_q[w][b*8 +: 8] <= init_byte(w*BPW + b);
        end
      end
    end else if (d_acc && d_ok && data_if.we) begin
      for (int unsigned b = 0; b < BPW; b++) begin
        if (data_if.be[b]) mem_q[d_idx][b*8 +: 8] <= data_if.wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      i_cnt_q <= '0;
      d_cnt_q <= '0;
      i_vld_q <= '0;
      i_err_q <= '0;
      d_vld_q <= '0;
      d_err_q <= '0;
      for (int s = 0; s < LATENCY; s++) begin
        i_data_q[s] <= '0;
        d_data_q[s] <= '0;
      end
    end else begin
      i_cnt_q <= i_cnt_d;
      d_cnt_q <= d_cnt_d;
      for (int s = LATENCY - 1; s > 0; s--) begin
        i_vld_q[s]  <= i_vld_q[s-1];
        i_err_q[s]  <= i_err_q[s-1];
        i_data_q[s] <= i_data_q[s-1];
        d_vld_q[s]  <= d_vld_q[s-1];
        d_err_q[s]  <= d_err_q[s-1];
        d_data_q[s] <= d_data_q[s-1];
      end
      i_vld_q[0]  <= i_acc;
      i_err_q[0]  <= i_acc && !i_ok;
      i_data_q[0] <= i_rdata_d;
      d_vld_q[0]  <= d_acc;
      d_err_q[0]  <= d_acc && !d_ok;
      d_data_q[0] <= d_rdata_d;
    end
  end

  assign instr_if.rvalid = i_vld_q[LATENCY-1];
  assign instr_if.err    = i_err_q[LATENCY-1];
  assign instr_if.rdata  = i_data_q[LATENCY-1];
  assign data_if.rvalid  = d_vld_q[LATENCY-1];
  assign data_if.err     = d_err_q[LATENCY-1];
  assign data_if.rdata   = d_data_q[LATENCY-1];

  // The fetch port never writes.
  logic unused_instr;
  assign unused_instr = ^{instr_if.we, instr_if.be, instr_if.wdata};

endmodule

// File: tb/tb_tb_dual_port_mem.sv
// Directed bench for tb_dual_port_mem: three instances sharing clock/reset.
//   u_a: LATENCY=1, no stall, program-style init image
//   u_b: LATENCY=4, no stall, ramp init (byte i = i)
//   u_c: LATENCY=1, STALL_PERIOD=3, ramp init
// Inputs are driven 1 ns after a rising edge, outputs looked at 3 ns after it.
module tb_tb_dual_port_mem;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  localparam logic [383:0] PLAN_INIT = {
    8'h13, 8'h80, 8'h02, 8'h00, 128'h0,
    8'h23, 8'h20, 8'h50, 8'h00, 32'h0,
    8'hEF, 8'h00, 8'h00, 8'h00, 128'h0
  };

  function automatic logic [383:0] ramp_init();
    logic [383:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[(47-i)*8 +: 8] = 8'(i);
    return r;
  endfunction
  localparam logic [383:0] RAMP_INIT = ramp_init();

  // Expected ramp word at an aligned byte address (little-endian).
  function automatic logic [31:0] ramp_word(input logic [31:0] a);
    logic [7:0] b0;
    b0 = a[7:0];
    return {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0};
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tb_dual_port_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ia_i ();
  tb_dual_port_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ia_d ();
  tb_dual_port_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ib_i ();
  tb_dual_port_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ib_d ();
  tb_dual_port_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ic_i ();
  tb_dual_port_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ic_d ();

  tb_dual_port_mem #(.INIT_CONTENT(PLAN_INIT), .LATENCY(1), .STALL_PERIOD(0)) u_a (
    .clk_i(clk), .rst_i(rst), .instr_if(ia_i), .data_if(ia_d));
  tb_dual_port_mem #(.INIT_CONTENT(RAMP_INIT), .LATENCY(4), .STALL_PERIOD(0)) u_b (
    .clk_i(clk), .rst_i(rst), .instr_if(ib_i), .data_if(ib_d));
  tb_dual_port_mem #(.INIT_CONTENT(RAMP_INIT), .LATENCY(1), .STALL_PERIOD(3)) u_c (
    .clk_i(clk), .rst_i(rst), .instr_if(ic_i), .data_if(ic_d));

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_port_a();
    ia_i.req = 0; ia_i.addr = '0; ia_i.we = 0; ia_i.be = '0; ia_i.wdata = '0;
    ia_d.req = 0; ia_d.addr = '0; ia_d.we = 0; ia_d.be = '0; ia_d.wdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        pg;
    logic [31:0] pa;
    int          idx;
    logic        eg;

    idle_port_a();
    ib_i.req = 0; ib_i.addr = '0; ib_i.we = 0; ib_i.be = '0; ib_i.wdata = '0;
    ib_d.req = 0; ib_d.addr = '0; ib_d.we = 0; ib_d.be = '0; ib_d.wdata = '0;
    ic_i.req = 0; ic_i.addr = '0; ic_i.we = 0; ic_i.be = '0; ic_i.wdata = '0;
    ic_d.req = 0; ic_d.addr = '0; ic_d.we = 0; ic_d.be = '0; ic_d.wdata = '0;

    // Reset state
    next_cycle(); #2;
    chk("rst_i_rvalid", ia_i.rvalid, 0);
    chk("rst_i_rdata",  ia_i.rdata, 0);
    chk("rst_i_err",    ia_i.err, 0);
    chk("rst_d_rvalid", ia_d.rvalid, 0);
    chk("rst_d_rdata",  ia_d.rdata, 0);
    chk("rst_d_err",    ia_d.err, 0);
    chk("rst_gnt",      {ia_i.gnt, ia_d.gnt}, 0);

    // Release; the stall counters are 0 in the first cycle after release.
    next_cycle();
    rst = 0;

    // Stall pattern 1,1,0 with held requests on u_c
    pg = 0; pa = '0; idx = 0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) next_cycle();
      ic_i.req  = (k < 9);
      ic_i.addr = 32'(idx * 4);
      #2;
      eg = (k < 9) && ((k % 3) != 2);
      chk("stall_gnt", ic_i.gnt, eg);
      chk("stall_rvalid", ic_i.rvalid, pg);
      if (pg) chk("stall_rdata", ic_i.rdata, ramp_word(pa));
      pg = eg;
      pa = ic_i.addr;
      if (eg) idx++;
    end
    ic_i.req = 0;

    // LATENCY=4 pipelined fetches on u_b
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      ib_i.req  = (k < 5);
      ib_i.addr = 32'(k * 4);
      #2;
      chk("lat_gnt", ib_i.gnt, (k < 5));
      chk("lat_rvalid", ib_i.rvalid, (k >= 4 && k <= 8));
      if (k >= 4 && k <= 8) chk("lat_rdata", ib_i.rdata, ramp_word(32'((k - 4) * 4)));
    end
    ib_i.req = 0;

    // Back-to-back fetches on u_a
    next_cycle(); ia_i.req = 1; ia_i.addr = 32'h00; #2;
    chk("fetch_gnt", ia_i.gnt, 1);
    chk("fetch_idle_rvalid", ia_i.rvalid, 0);
    next_cycle(); ia_i.addr = 32'h14; #2;
    chk("fetch0_rvalid", ia_i.rvalid, 1);
    chk("fetch0_rdata", ia_i.rdata, 32'h0002_8013);
    chk("fetch0_err", ia_i.err, 0);
    next_cycle(); ia_i.addr = 32'h1C; #2;
    chk("fetch1_rvalid", ia_i.rvalid, 1);
    chk("fetch1_rdata", ia_i.rdata, 32'h0050_2023);
    next_cycle(); ia_i.req = 0; #2;
    chk("fetch2_rvalid", ia_i.rvalid, 1);
    chk("fetch2_rdata", ia_i.rdata, 32'h0000_00EF);
    next_cycle(); #2;
    chk("fetch_end_rvalid", ia_i.rvalid, 0);

    // Byte-enable write then read back
    next_cycle();
    ia_d.req = 1; ia_d.we = 1; ia_d.be = 4'b0101; ia_d.wdata = 32'hAABB_CCDD; ia_d.addr = 32'h40;
    #2;
    chk("wr_gnt", ia_d.gnt, 1);
    next_cycle(); ia_d.we = 0; ia_d.be = 4'hF; #2;
    chk("wr_rvalid", ia_d.rvalid, 1);
    chk("wr_rdata", ia_d.rdata, 0);
    chk("wr_err", ia_d.err, 0);
    next_cycle(); ia_d.req = 0; #2;
    chk("be_rd_rvalid", ia_d.rvalid, 1);
    chk("be_rd_rdata", ia_d.rdata, 32'h00BB_00DD);

    // Error responses and the last legal word
    next_cycle();
    ia_i.req = 1; ia_i.addr = 32'h1002;
    ia_d.req = 1; ia_d.we = 0; ia_d.addr = 32'h1000;
    #2;
    next_cycle();
    ia_i.addr = 32'h0002;
    ia_d.we = 1; ia_d.be = 4'hF; ia_d.wdata = 32'hDEAD_BEEF; ia_d.addr = 32'h1000;
    #2;
    chk("err_fetch_oor_err", ia_i.err, 1);
    chk("err_fetch_oor_rdata", ia_i.rdata, 0);
    chk("err_data_rd_rvalid", ia_d.rvalid, 1);
    chk("err_data_rd_err", ia_d.err, 1);
    chk("err_data_rd_rdata", ia_d.rdata, 0);
    next_cycle();
    ia_i.req = 0; ia_d.we = 0; ia_d.addr = 32'h0;
    #2;
    chk("err_fetch_mis_rvalid", ia_i.rvalid, 1);
    chk("err_fetch_mis_err", ia_i.err, 1);
    chk("err_fetch_mis_rdata", ia_i.rdata, 0);
    chk("err_data_wr_err", ia_d.err, 1);
    next_cycle(); ia_d.addr = 32'hFFC; #2;
    chk("oor_wr_no_effect", ia_d.rdata, 32'h0002_8013);
    chk("oor_wr_no_effect_err", ia_d.err, 0);
    next_cycle(); ia_d.req = 0; #2;
    chk("last_word_err", ia_d.err, 0);
    chk("last_word_rvalid", ia_d.rvalid, 1);

    // Same-edge fetch and data write to 0x08
    next_cycle();
    ia_i.req = 1; ia_i.addr = 32'h08;
    ia_d.req = 1; ia_d.we = 1; ia_d.be = 4'hF; ia_d.wdata = 32'h1234_5678; ia_d.addr = 32'h08;
    #2;
    next_cycle(); ia_d.req = 0; ia_d.we = 0; #2;
    chk("rbw_old_rdata", ia_i.rdata, 0);
    chk("rbw_old_rvalid", ia_i.rvalid, 1);
    chk("rbw_wr_rvalid", ia_d.rvalid, 1);
    next_cycle(); ia_i.req = 0; #2;
    chk("rbw_new_rdata", ia_i.rdata, 32'h1234_5678);

    // Reset with three fetches in flight on u_b
    for (int k = 0; k < 3; k++) begin
      next_cycle(); ib_i.req = 1; ib_i.addr = 32'(k * 4);
    end
    next_cycle(); ib_i.req = 0; rst = 1; #2;
    chk("midrst_rvalid_in_reset", ib_i.rvalid, 0);
    next_cycle(); rst = 0; #2;
    for (int k = 0; k < 6; k++) begin
      chk("midrst_rvalid_after", ib_i.rvalid, 0);
      next_cycle(); #2;
    end
    ia_i.req = 1; ia_i.addr = 32'h08; #2;
    next_cycle(); ia_i.req = 0; #2;
    chk("midrst_reload_rvalid", ia_i.rvalid, 1);
    chk("midrst_reload_word08", ia_i.rdata, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
